crc8_frame_streamer: RTL

- Upstream feeder for the CRC8 checker (CRC8816).
- Accepts frames as 32-bit words over a valid/ready handshake and serializes them MSB-byte-first into the checker's byte stream (valid/last/data), one byte per cycle.
- After each frame it waits for the checker's done pulse, captures its match result, and enforces a maximum frame length and a done timeout.

---
 rtl/crc8_frame_streamer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/crc8_frame_streamer.sv
// crc8_frame_streamer
// Feeds the CRC8 checker. It takes frames as 32-bit words over a valid/ready
// handshake and sends them out one byte per cycle, most significant byte
// first, with a last-byte marker. After each frame it waits for the checker's
// done pulse and reports ok/bad/timeout. Frames longer than MAX_FRAME_BYTES
// are truncated and their remaining words are dropped.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data/i_in_nbytes/i_in_eop
//                       word input; i_in_nbytes is the valid byte count minus 1,
//                       and the valid bytes are the top ones
//   o_valid/o_last/o_data
//                       byte stream to the checker
//   i_crc_done/i_crc_match
//                       checker result; used only while waiting for done
//   o_frame_ok/o_frame_bad/o_timeout/o_overflow
//                       one-cycle status pulses
//   o_byte_count        bytes sent in the current or most recent frame
//   o_frame_count       frames completed, wraps at 16 bits
module crc8_frame_streamer #(
  parameter int MAX_FRAME_BYTES = 64,
  parameter int DONE_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_data,
  input  logic [1:0]  i_in_nbytes,
  input  logic        i_in_eop,
  output logic        o_valid,
  output logic        o_last,
  output logic [7:0]  o_data,
  input  logic        i_crc_done,
  input  logic        i_crc_match,
  output logic        o_frame_ok,
  output logic        o_frame_bad,
  output logic        o_timeout,
  output logic        o_overflow,
  output logic [7:0]  o_byte_count,
  output logic [15:0] o_frame_count
);

  localparam logic [7:0] MAX_COUNT  = 8'(MAX_FRAME_BYTES);
  localparam logic [7:0] TIMER_LAST = 8'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STALL,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t      state_reg, state_next;

  logic [31:0] word_reg;        // unsent bytes of the current word, top-aligned
  logic [1:0]  remaining_reg;   // bytes left in the word after the one on o_data
  logic        eop_reg;
  logic        discard_reg;
  logic [7:0]  timer_reg;
  logic        valid_reg, last_reg, ok_reg, bad_reg, timeout_reg, overflow_reg;
  logic [7:0]  data_reg;
  logic [7:0]  byte_count_reg;
  logic [15:0] frame_count_reg;

  logic        in_ready, in_hs;
  logic        word_end;
  logic        load_new, emit_next, emit;
  logic [7:0]  src_byte;
  logic        src_word_end, src_eop;
  logic [7:0]  count_next;
  logic        hit_max, last_next, overflow_next;
  logic        wait_done, wait_expire;
  logic [31:0] word_shifted;

  // Word register shifted up by one byte lane, zero filled.
  for (genvar gi = 0; gi < 4; gi++) begin : g_shift
    if (gi == 0) begin : g_fill
      assign word_shifted[7:0] = 8'h00;
    end else begin : g_move
      assign word_shifted[8*gi +: 8] = word_reg[8*(gi-1) +: 8];
    end
  end

  assign word_end = (remaining_reg == 2'd0);
  assign in_hs    = i_in_valid && in_ready;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      word_reg        <= 32'h0;
      remaining_reg   <= 2'd0;
      eop_reg         <= 1'b0;
      discard_reg     <= 1'b0;
      timer_reg       <= 8'd0;
      valid_reg       <= 1'b0;
      last_reg        <= 1'b0;
      data_reg        <= 8'h00;
      ok_reg          <= 1'b0;
      bad_reg         <= 1'b0;
      timeout_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
      byte_count_reg  <= 8'd0;
      frame_count_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= emit;
      last_reg     <= last_next;
      overflow_reg <= overflow_next;
      ok_reg       <= wait_done && i_crc_match;
      bad_reg      <= wait_done && !i_crc_match;
      timeout_reg  <= wait_expire;
      timer_reg    <= (state_reg == ST_WAIT) ? timer_reg + 8'd1 : 8'd0;
      if (emit) begin
        data_reg       <= src_byte;
        byte_count_reg <= count_next;
      end
      if (load_new) begin
        word_reg      <= {i_in_data[23:0], 8'h00};
        remaining_reg <= i_in_nbytes;
        eop_reg       <= i_in_eop;
      end else if (emit_next) begin
        word_reg      <= word_shifted;
        remaining_reg <= remaining_reg - 2'd1;
      end
      // Drop the rest of the frame only when words are still to come; a
      // truncation inside the eop word has nothing left upstream to discard.
      if (overflow_next && !src_eop) begin
        discard_reg <= 1'b1;
      end else if (state_reg == ST_DISCARD && in_hs && i_in_eop) begin
        discard_reg <= 1'b0;
      end
      if (wait_done || wait_expire) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (in_hs) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (last_reg)      state_next = ST_WAIT;
        else if (word_end) state_next = in_hs ? ST_SHIFT : ST_STALL;
      end
      ST_STALL:   if (in_hs) state_next = ST_SHIFT;
      ST_WAIT: begin
        if (i_crc_done || timer_reg == TIMER_LAST)
          state_next = discard_reg ? ST_DISCARD : ST_IDLE;
      end
      ST_DISCARD: if (in_hs && i_in_eop) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      ST_IDLE, ST_STALL, ST_DISCARD: in_ready = 1'b1;
      // Chain the next word only off the final byte of a non-eop word that
      // did not just hit the length cap.
      ST_SHIFT: in_ready = word_end && !eop_reg && (byte_count_reg != MAX_COUNT);
      default:  in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;

    load_new  = in_hs && (state_reg == ST_IDLE || state_reg == ST_SHIFT ||
                          state_reg == ST_STALL);
    emit_next = (state_reg == ST_SHIFT) && !last_reg && !word_end;
    emit      = load_new || emit_next;

    if (load_new) begin
      src_byte     = i_in_data[31:24];
      src_word_end = (i_in_nbytes == 2'd0);
      src_eop      = i_in_eop;
    end else begin
      src_byte     = word_reg[31:24];
      src_word_end = (remaining_reg == 2'd1);
      src_eop      = eop_reg;
    end

    // Count includes the byte being placed on o_data; a new frame restarts at 1.
    count_next    = (state_reg == ST_IDLE) ? 8'd1 : byte_count_reg + 8'd1;
    hit_max       = (count_next == MAX_COUNT);
    last_next     = emit && ((src_word_end && src_eop) || hit_max);
    overflow_next = emit && hit_max && !(src_word_end && src_eop);

    // A done coinciding with the final timer cycle wins over the timeout.
    wait_done   = (state_reg == ST_WAIT) && i_crc_done;
    wait_expire = (state_reg == ST_WAIT) && !i_crc_done && (timer_reg == TIMER_LAST);
  end

  assign o_in_ready    = in_ready;
  assign o_valid       = valid_reg;
  assign o_last        = last_reg;
  assign o_data        = data_reg;
  assign o_frame_ok    = ok_reg;
  assign o_frame_bad   = bad_reg;
  assign o_timeout     = timeout_reg;
  assign o_overflow    = overflow_reg;
  assign o_byte_count  = byte_count_reg;
  assign o_frame_count = frame_count_reg;

endmodule
